// File: rtl/expr_result_unpacker.sv
// Unpacks the 90-bit expression result bus into 18 extended fields, one per beat on a valid/ready stream.
// Latency: accept in cycle N gives the first beat in cycle N+1; out_* hold while out_ready=0 and in_ready=0 while emitting.
module expr_result_unpacker #(
  parameter int OUT_W    = 8,
  parameter bit SIGN_EXT = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [89:0]      in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_idx,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic [OUT_W-1:0] out_xor,
  output logic [CNT_W-1:0] vec_cnt
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state, state_nxt;
  logic [89:0]      shadow;
  logic [4:0]       idx;
  logic [OUT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             accept, beat, last_beat;
  logic [OUT_W-1:0] sel;

  logic [17:0][OUT_W-1:0] field_ext;

  // Each group of three fields (widths 4,5,6) occupies 15 bits, groups packed from bit 89 down.
  for (genvar k = 0; k < 18; k++) begin : g_field
    localparam int  W   = 4 + (k % 3);
    localparam int  OFS = (k % 3 == 0) ? 0 : ((k % 3 == 1) ? 4 : 9);
    localparam int  MSB = 89 - 15 * (k / 3) - OFS;
    localparam int  LSB = MSB - W + 1;
    localparam bit  SGN = ((k / 3) % 2) == 1;
    logic [OUT_W-1:0] ext;
    always_comb begin
      ext        = {OUT_W{SIGN_EXT && SGN && shadow[MSB]}};
      ext[W-1:0] = shadow[MSB:LSB];
    end
    assign field_ext[k] = ext;
  end

  always_comb begin
    sel = '0;
    for (int k = 0; k < 18; k++) begin
      if (idx == 5'(k)) sel = field_ext[k];
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    beat      = 1'b0;
    last_beat = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          beat = 1'b1;
          if (idx == 5'd17) begin
            last_beat = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      idx    <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        shadow <= in_y;
        idx    <= '0;
        acc    <= '0;
      end else if (beat) begin
        acc <= acc ^ sel;
        idx <= last_beat ? 5'd0 : idx + 5'd1;
      end
      if (last_beat) cnt <= cnt + 1'b1;
    end
  end

  // Data outputs read as zero outside EMIT so IDLE matches the reset picture.
  assign out_idx  = idx;
  assign out_data = out_valid ? sel : '0;
  assign out_last = out_valid && (idx == 5'd17);
  assign out_xor  = out_valid ? (acc ^ sel) : '0;
  assign vec_cnt  = cnt;

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Scoreboarded bench: a signed-extend instance and a zero-extend instance with a 4-bit counter share one stimulus.
module tb_expr_result_unpacker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [89:0] in_y = '0;

  logic        in_ready, out_valid, out_last;
  logic [4:0]  out_idx;
  logic [7:0]  out_data, out_xor;
  logic [15:0] vec_cnt;

  logic        in_ready_z, out_valid_z, out_last_z;
  logic [4:0]  out_idx_z;
  logic [7:0]  out_data_z, out_xor_z;
  logic [3:0]  vec_cnt_z;

  expr_result_unpacker #(.OUT_W(8), .SIGN_EXT(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
    .out_last(out_last), .out_xor(out_xor), .vec_cnt(vec_cnt)
  );

  expr_result_unpacker #(.OUT_W(8), .SIGN_EXT(1'b0), .CNT_W(4)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z), .in_y(in_y),
    .out_valid(out_valid_z), .out_ready(out_ready), .out_idx(out_idx_z), .out_data(out_data_z),
    .out_last(out_last_z), .out_xor(out_xor_z), .vec_cnt(vec_cnt_z)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] idx;
    logic [7:0] data;
    logic       last;
    logic [7:0] x;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int nvec = 0;
  logic prev_last = 1'b0;
  logic [7:0] seen0 [18];
  logic [7:0] seen1 [18];
  logic [7:0] lastx0 = '0;
  logic [7:0] lastx1 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk the bus MSB-first with a moving bit pointer.
  task automatic push_vec(input logic [89:0] y);
    int pos;
    int w;
    logic [89:0] sh;
    logic [7:0] f, mask, e1;
    logic [7:0] a0, a1;
    pos = 89;
    a0 = '0;
    a1 = '0;
    for (int k = 0; k < 18; k++) begin
      w    = 4 + (k % 3);
      sh   = y >> (pos - w + 1);
      mask = 8'((1 << w) - 1);
      f    = sh[7:0] & mask;
      e1   = (((k / 3) % 2 == 1) && f[w-1]) ? (f | ~mask) : f;
      a1   = a1 ^ e1;
      a0   = a0 ^ f;
      q0.push_back('{idx: 5'(k), data: e1, last: (k == 17), x: a1});
      q1.push_back('{idx: 5'(k), data: f,  last: (k == 17), x: a0});
      pos  = pos - w;
    end
  endtask

  task automatic mon(input int which, input logic [4:0] i, input logic [7:0] d,
                     input logic l, input logic [7:0] x);
    beat_t e;
    int qs;
    qs = (which == 0) ? q0.size() : q1.size();
    checks++;
    assert (qs != 0) else begin
      errors++;
      $error("FAIL unexpected_beat dut%0d observed idx=%0d expected no beat", which, i);
    end
    if (qs != 0) begin
      if (which == 0) e = q0.pop_front();
      else            e = q1.pop_front();
      check($sformatf("beat_idx%0d", which),  32'(i), 32'(e.idx));
      check($sformatf("beat_data%0d_i%0d", which, e.idx), 32'(d), 32'(e.data));
      check($sformatf("beat_last%0d_i%0d", which, e.idx), 32'(l), 32'(e.last));
      if (e.last) check($sformatf("beat_xor%0d", which), 32'(x), 32'(e.x));
    end
    if (i < 5'd18) begin
      if (which == 0) seen0[i] = d;
      else            seen1[i] = d;
    end
    if (l) begin
      if (which == 0) lastx0 = x;
      else            lastx1 = x;
    end
  endtask

  // Sample at negedge: fired beats are popped, pending accepts push the model's beats.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_last = 1'b0;
    end else begin
      check("ready_vs_valid", 32'(in_ready), 32'(!out_valid));
      if (prev_last) check("accept_gap", 32'(in_ready), 32'(1));
      prev_last = 1'b0;
      if (out_valid && out_ready) begin
        mon(0, out_idx, out_data, out_last, out_xor);
        prev_last = out_last;
      end
      if (out_valid_z && out_ready) mon(1, out_idx_z, out_data_z, out_last_z, out_xor_z);
      if (in_valid && in_ready) begin
        push_vec(in_y);
        accepts++;
      end
    end
  end

  task automatic send_vec(input logic [89:0] y);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready_timeout", 32'(in_ready), 32'(1));
    in_y = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    nvec++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(q0.size() == 0 && q1.size() == 0 && in_ready) && n < 200);
    check("idle_timeout", 32'(n < 200), 32'(1));
  endtask

  task automatic wait_idx(input logic [4:0] target);
    int n;
    n = 0;
    while (!(out_valid && out_idx == target) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_idx_timeout", 32'(n < 100), 32'(1));
  endtask

  task automatic check_cnt();
    check("vec_cnt", 32'(vec_cnt), 32'(nvec % 65536));
    check("vec_cnt_z", 32'(vec_cnt_z), 32'(nvec % 16));
  endtask

  initial begin
    logic [89:0] v;
    logic [95:0] r;
    int n;

    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_idx", 32'(out_idx), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    check("rst_out_xor", 32'(out_xor), 32'(0));
    check("rst_vec_cnt", 32'(vec_cnt), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // T1/T2: y0=F, y3=1000
    v = '0;
    v[89:86] = 4'hF;
    v[74:71] = 4'b1000;
    send_vec(v);
    check("first_beat_latency", 32'(out_valid), 32'(1));
    check("first_beat_idx", 32'(out_idx), 32'(0));
    wait_idle();
    check("t1_idx0", 32'(seen0[0]), 32'h0F);
    check("t1_idx3", 32'(seen0[3]), 32'hF8);
    check("t1_xor", 32'(lastx0), 32'hF7);
    check("t2_idx3", 32'(seen1[3]), 32'h08);
    check("t2_xor", 32'(lastx1), 32'h07);
    check("t1_out_valid_idle", 32'(out_valid), 32'(0));
    check_cnt();

    // T3: signed 6-bit y17 vs unsigned 6-bit y2
    v = '0;
    v[5:0]   = 6'b100000;
    v[80:75] = 6'b100000;
    send_vec(v);
    wait_idle();
    check("t3_idx17", 32'(seen0[17]), 32'hE0);
    check("t3_idx2", 32'(seen0[2]), 32'h20);
    check("t3_idx17_z", 32'(seen1[17]), 32'h20);
    check_cnt();

    // T4: stall at idx 5
    r = {$urandom(), $urandom(), $urandom()};
    send_vec(r[89:0]);
    wait_idx(5'd5);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("t4_hold_valid", 32'(out_valid), 32'(1));
      check("t4_hold_idx", 32'(out_idx), 32'(5));
      if (q0.size() != 0) check("t4_hold_data", 32'(out_data), 32'(q0[0].data));
      check("t4_hold_last", 32'(out_last), 32'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_resume_idx", 32'(out_idx), 32'(6));
    wait_idle();
    check_cnt();

    // T5: in_valid held high across three vectors
    n = 0;
    accepts = 0;
    r = {$urandom(), $urandom(), $urandom()};
    in_y = r[89:0];
    in_valid = 1'b1;
    while (accepts < 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("t5_accepts", 32'(accepts), 32'(3));
    nvec = nvec + 3;
    wait_idle();
    check_cnt();

    // T6: reset at idx 9
    r = {$urandom(), $urandom(), $urandom()};
    send_vec(r[89:0]);
    wait_idx(5'd9);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    nvec = 0;
    #1;
    check("t6_out_valid", 32'(out_valid), 32'(0));
    check("t6_in_ready", 32'(in_ready), 32'(1));
    check("t6_out_idx", 32'(out_idx), 32'(0));
    check("t6_vec_cnt", 32'(vec_cnt), 32'(0));
    check("t6_vec_cnt_z", 32'(vec_cnt_z), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    r = {$urandom(), $urandom(), $urandom()};
    send_vec(r[89:0]);
    check("t6_restart_idx", 32'(out_idx), 32'(0));
    wait_idle();
    check_cnt();

    // Counter wrap: the 4-bit instance passes all-ones and returns to zero
    for (int i = 0; i < 16; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      send_vec(r[89:0]);
      wait_idle();
      check_cnt();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $error("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
